// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract result capture path.
package addsub_pkg;

  localparam int unsigned FLAG_V  = 0;
  localparam int unsigned FLAG_C  = 1;
  localparam int unsigned FLAG_Z  = 2;
  localparam int unsigned FLAG_N  = 3;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned SUM_W   = 4;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } addsub_flags_t;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    addsub_flags_t    flags;
  } addsub_entry_t;

endpackage

// File: rtl/addsub_res_fifo.sv
// Generic synchronous FIFO; occupancy counter separates full from empty.
module addsub_res_fifo #(
  parameter int unsigned WIDTH_DATA = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH_DATA-1:0]   wdata,
  output logic [WIDTH_DATA-1:0]   rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q, count_d;
  logic [WIDTH_DATA-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Gate the head so stale or never-written storage reads as zero when empty.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/addsub_result_buffer.sv
// Captures adder results with N/Z/C/V status into a FIFO; keeps a sticky overflow bit.
module addsub_result_buffer
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_sticky,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_sum,
  input  logic                    in_cout,
  input  logic                    in_sub,
  input  logic                    in_a_msb,
  input  logic                    in_b_msb,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_sum,
  output logic [3:0]              out_flags,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    sticky_ovf
);

  localparam int unsigned ENTRY_W = WIDTH + FLAGS_W;

  logic [FLAGS_W-1:0] flags;
  addsub_flags_t      flags_s;
  logic               push, pop, full, empty;
  logic [ENTRY_W-1:0] rdata;
  logic               sticky_q;

  // B's msb is taken before inversion, so fold the Sub control in for V.
  always_comb begin
    flags         = '0;
    flags[FLAG_N] = in_sum[WIDTH-1];
    flags[FLAG_Z] = (in_sum == '0);
    flags[FLAG_C] = in_cout;
    flags[FLAG_V] = (in_a_msb ~^ (in_b_msb ^ in_sub)) & (in_a_msb ^ in_sum[WIDTH-1]);
  end

  assign flags_s = addsub_flags_t'(flags);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  addsub_res_fifo #(
    .WIDTH_DATA (ENTRY_W),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({in_sum, flags}),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign out_sum   = rdata[ENTRY_W-1:FLAGS_W];
  assign out_flags = rdata[FLAGS_W-1:0];

  // An overflowing push beats a clear on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (push && flags_s.v) begin
      sticky_q <= 1'b1;
    end else if (clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_addsub_result_buffer.sv
// Directed and random checks of addsub_result_buffer against a queue-based model.
module tb_addsub_result_buffer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, clr_sticky, in_valid, in_ready, in_cout, in_sub, in_a_msb, in_b_msb;
  logic [3:0] in_sum, out_sum, out_flags;
  logic       out_valid, out_ready, sticky_ovf;
  logic [2:0] count;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] mq[$];
  logic       ms;
  logic [7:0] ref_e;

  always #5 clk = ~clk;

  addsub_result_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_sticky (clr_sticky),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_cout    (in_cout),
    .in_sub     (in_sub),
    .in_a_msb   (in_a_msb),
    .in_b_msb   (in_b_msb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_flags  (out_flags),
    .count      (count),
    .sticky_ovf (sticky_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Emulates the 4-bit adder and derives expected flags from signed arithmetic.
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic sub);
    logic [4:0] r;
    int         sa, sb, res;
    logic [3:0] nb;
    nb  = ~b;
    r   = sub ? ({1'b0, a} + {1'b0, nb} + 5'd1) : ({1'b0, a} + {1'b0, b});
    sa  = a[3] ? int'(a) - 16 : int'(a);
    sb  = b[3] ? int'(b) - 16 : int'(b);
    res = sub ? sa - sb : sa + sb;
    in_valid = v;
    in_sum   = r[3:0];
    in_cout  = r[4];
    in_sub   = sub;
    in_a_msb = a[3];
    in_b_msb = b[3];
    ref_e    = {r[3:0], r[3], (r[3:0] == 4'd0), r[4], (res > 7 || res < -8)};
  endtask

  task automatic cycle();
    logic       push, pop;
    logic [7:0] e, head;
    push = in_valid && (mq.size() < DEPTH);
    pop  = out_ready && (mq.size() != 0);
    e    = ref_e;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      ms = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (push && e[0]) ms = 1'b1;
      else if (clr_sticky) ms = 1'b0;
    end
    @(negedge clk);
    head = (mq.size() != 0) ? mq[0] : 8'h00;
    chk("out_valid", out_valid, (mq.size() != 0));
    chk("in_ready", in_ready, (mq.size() < DEPTH));
    chk("count", count, mq.size());
    chk("out_sum", out_sum, head[7:4]);
    chk("out_flags", out_flags, head[3:0]);
    chk("sticky_ovf", sticky_ovf, ms);
  endtask

  initial begin
    ms         = 1'b0;
    rst_n      = 1'b0;
    clr_sticky = 1'b0;
    out_ready  = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    rst_n = 1'b1;

    // Single result: 7 + (-3)
    drive(1'b1, 4'd7, 4'd13, 1'b0);
    cycle();
    chk("t1_sum", out_sum, 4);
    chk("t1_flags", out_flags, 4'b0010);
    chk("t1_sticky", sticky_ovf, 0);

    // Sequence with consumer always ready
    drive(1'b1, 4'd15, 4'd15, 1'b1);
    cycle();
    chk("seq0_sum", out_sum, 0);
    chk("seq0_flags", out_flags, 4'b0110);
    drive(1'b1, 4'd3, 4'd7, 1'b1);
    cycle();
    chk("seq1_sum", out_sum, 12);
    chk("seq1_flags", out_flags, 4'b1000);
    drive(1'b1, 4'd14, 4'd13, 1'b0);
    cycle();
    chk("seq2_sum", out_sum, 11);
    chk("seq2_flags", out_flags, 4'b1010);
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    cycle();

    // Overflow and sticky clear/set priority
    drive(1'b1, 4'd7, 4'd1, 1'b0);
    cycle();
    chk("ovf_flags", out_flags, 4'b1001);
    chk("ovf_sticky", sticky_ovf, 1);
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    clr_sticky = 1'b1;
    cycle();
    chk("clr_sticky", sticky_ovf, 0);
    drive(1'b1, 4'd7, 4'd1, 1'b0);
    cycle();
    chk("set_wins", sticky_ovf, 1);
    clr_sticky = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    cycle();

    // Backpressure: fill, hold fifth, single pop, accept fifth
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i + 1), 4'd2, 1'b0);
      cycle();
    end
    chk("bp_count_full", count, 4);
    chk("bp_in_ready_full", in_ready, 0);
    drive(1'b1, 4'd9, 4'd2, 1'b1);
    cycle();
    chk("bp_held", count, 4);
    out_ready = 1'b1;
    cycle();
    chk("bp_after_pop_ready", in_ready, 1);
    chk("bp_after_pop_count", count, 3);
    out_ready = 1'b0;
    cycle();
    chk("bp_fifth_in", count, 4);
    out_ready = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    repeat (5) cycle();

    // Streaming, wraps pointers several times
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
      cycle();
      chk("stream_count", count, 1);
    end
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    cycle();

    // Reset mid-operation
    out_ready = 1'b0;
    drive(1'b1, 4'd7, 4'd1, 1'b0);
    cycle();
    drive(1'b1, 4'd2, 4'd3, 1'b0);
    cycle();
    drive(1'b1, 4'd5, 4'd6, 1'b1);
    cycle();
    chk("mid_count3", count, 3);
    chk("mid_sticky_set", sticky_ovf, 1);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_sticky", sticky_ovf, 0);
    rst_n = 1'b1;
    drive(1'b1, 4'd7, 4'd13, 1'b0);
    cycle();
    chk("post_rst_sum", out_sum, 4);
    chk("post_rst_count", count, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      out_ready  = 1'($urandom_range(0, 1));
      clr_sticky = ($urandom_range(0, 7) == 0);
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
